// File: rtl/vx_gpr_seq_reader_if.sv
// Operand-read request, operand-bundle response and writeback bundle for the GPR reader.
// Latency: none; this file only carries wires.
// Backpressure: req and rsp use valid/ready; writeback has no ready and is always accepted.
interface vx_gpr_seq_reader_if #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4
);
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int DW    = NUM_THREADS * 32;

    // Request side
    logic             req_valid;
    logic             req_ready;
    logic [WID_W-1:0] req_wid;
    logic [4:0]       req_rs1;
    logic [4:0]       req_rs2;
    logic [4:0]       req_rs3;
    logic             req_use_rs3;

    // Response side
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WID_W-1:0] rsp_wid;
    logic [DW-1:0]    rsp_rs1_data;
    logic [DW-1:0]    rsp_rs2_data;
    logic [DW-1:0]    rsp_rs3_data;

    // Writeback side
    logic                   wb_valid;
    logic [WID_W-1:0]       wb_wid;
    logic [4:0]             wb_rd;
    logic [NUM_THREADS-1:0] wb_tmask;
    logic [DW-1:0]          wb_data;

    // The reader block itself
    modport slave (
        input  req_valid, req_wid, req_rs1, req_rs2, req_rs3, req_use_rs3,
        output req_ready,
        output rsp_valid, rsp_wid, rsp_rs1_data, rsp_rs2_data, rsp_rs3_data,
        input  rsp_ready,
        input  wb_valid, wb_wid, wb_rd, wb_tmask, wb_data
    );

    // Whoever issues requests, consumes bundles and drives writeback
    modport master (
        output req_valid, req_wid, req_rs1, req_rs2, req_rs3, req_use_rs3,
        input  req_ready,
        input  rsp_valid, rsp_wid, rsp_rs1_data, rsp_rs2_data, rsp_rs3_data,
        output rsp_ready,
        output wb_valid, wb_wid, wb_rd, wb_tmask, wb_data
    );
endinterface

// File: rtl/vx_gpr_seq_reader.sv
// GPR storage plus sequential operand reader: one read port, one operand captured per cycle.
// Latency: bundle valid 3 cycles after request accept (4 when rs3 is used), plus rsp stall.
// Backpressure: req_ready only in IDLE; bundle held in RSP until rsp_ready; writeback never stalls.
module vx_gpr_seq_reader #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    vx_gpr_seq_reader_if.slave    bus
);
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int DW    = NUM_THREADS * 32;
    localparam int NREGS = NUM_WARPS * 32;
    localparam int IDX_W = WID_W + 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        RD3  = 3'd3,
        RSP  = 3'd4
    } state_e;

    state_e state_q, state_d;
    logic   req_ready;
    logic   rsp_valid;

    // Latched request
    logic [WID_W-1:0] wid_q;
    logic [4:0]       rs1_q;
    logic [4:0]       rs2_q;
    logic [4:0]       rs3_q;
    logic             use_rs3_q;

    // Operand bundle registers
    logic [WID_W-1:0] rsp_wid_q;
    logic [DW-1:0]    rsp_rs1_q;
    logic [DW-1:0]    rsp_rs2_q;
    logic [DW-1:0]    rsp_rs3_q;

    // Register file: row index is {warp, reg}; each row holds all lanes
    logic [DW-1:0]    gpr_q [NREGS];
    logic [DW-1:0]    wb_bmask;

    // Single read port
    logic [4:0]       rd_idx;
    logic [IDX_W-1:0] rd_addr;
    logic [DW-1:0]    rd_data;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) state_d = RD1;
            end
            RD1:     state_d = RD2;
            RD2:     state_d = use_rs3_q ? RD3 : RSP;
            RD3:     state_d = RSP;
            RSP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the request fields on the accept handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wid_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rs3_q     <= '0;
            use_rs3_q <= 1'b0;
        end else if (state_q == IDLE && bus.req_valid) begin
            wid_q     <= bus.req_wid;
            rs1_q     <= bus.req_rs1;
            rs2_q     <= bus.req_rs2;
            rs3_q     <= bus.req_rs3;
            use_rs3_q <= bus.req_use_rs3;
        end
    end

    // Pick which operand index the read port serves this cycle
    always_comb begin
        rd_idx = rs1_q;
        case (state_q)
            RD2:     rd_idx = rs2_q;
            RD3:     rd_idx = rs3_q;
            default: rd_idx = rs1_q;
        endcase
    end

    assign rd_addr = {wid_q, rd_idx};

    // Array read of the pre-edge contents, so a same-cycle write is not visible; x0 forced to 0
    always_comb begin
        rd_data = '0;
        if (rd_idx != 5'd0) rd_data = gpr_q[rd_addr];
    end

    // Expand the per-lane write mask to a bit mask
    always_comb begin
        wb_bmask = '0;
        for (int l = 0; l < NUM_THREADS; l++) begin
            wb_bmask[32*l +: 32] = {32{bus.wb_tmask[l]}};
        end
    end

    // One storage row per (warp, reg); x0 rows are never written
    for (genvar g = 0; g < NREGS; g++) begin : g_row
        localparam int W = g / 32;
        localparam int R = g % 32;
        logic hit;
        assign hit = bus.wb_valid && (R != 0) && (bus.wb_rd == 5'(R)) && (bus.wb_wid == WID_W'(W));

        // Lane-masked writeback into this row
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)    gpr_q[g] <= '0;
            else if (hit) gpr_q[g] <= (gpr_q[g] & ~wb_bmask) | (bus.wb_data & wb_bmask);
        end
    end

    // Operand captures, one per read state; rs3 cleared when not requested
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_wid_q <= '0;
            rsp_rs1_q <= '0;
            rsp_rs2_q <= '0;
            rsp_rs3_q <= '0;
        end else begin
            case (state_q)
                RD1: begin
                    rsp_rs1_q <= rd_data;
                    rsp_wid_q <= wid_q;
                end
                RD2: begin
                    rsp_rs2_q <= rd_data;
                    if (!use_rs3_q) rsp_rs3_q <= '0;
                end
                RD3:     rsp_rs3_q <= rd_data;
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_wid      = rsp_wid_q;
    assign bus.rsp_rs1_data = rsp_rs1_q;
    assign bus.rsp_rs2_data = rsp_rs2_q;
    assign bus.rsp_rs3_data = rsp_rs3_q;
endmodule

// File: tb/tb_vx_gpr_seq_reader.sv
// Directed bench for vx_gpr_seq_reader with a queue-based scoreboard and separate monitor.
// Latency: checks bundle valid rise at accept+3 / accept+4.
// Backpressure: exercises rsp_ready stalls and a request queued behind a stalled bundle.
module tb_vx_gpr_seq_reader;
    localparam int NT = 4;
    localparam int NW = 4;
    localparam int DW = NT * 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vx_gpr_seq_reader_if #(.NUM_THREADS(NT), .NUM_WARPS(NW)) bus ();

    vx_gpr_seq_reader #(.NUM_THREADS(NT), .NUM_WARPS(NW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]    wid;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] d3;
        int            rise;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input logic [31:0] x);
        return {NT{x}};
    endfunction

    // Single writeback: valid for exactly one clock edge
    task automatic wb(input logic [1:0] wid, input logic [4:0] rd, input logic [3:0] m,
                      input logic [DW-1:0] d);
        @(posedge clk); #1;
        bus.wb_valid = 1'b1;
        bus.wb_wid   = wid;
        bus.wb_rd    = rd;
        bus.wb_tmask = m;
        bus.wb_data  = d;
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
    endtask

    // Issue one request; optionally push its expected bundle and optionally
    // write (wid, rdw_rd) during the cycle after acceptance (the rs1 capture cycle)
    task automatic issue(input logic [1:0] wid, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] r3, input logic u3,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2, input logic [DW-1:0] e3,
                         input bit push, input bit rdw = 1'b0,
                         input logic [4:0] rdw_rd = 5'd0, input logic [DW-1:0] rdw_d = '0);
        bit   done = 1'b0;
        exp_t e;
        @(posedge clk); #1;
        bus.req_valid   = 1'b1;
        bus.req_wid     = wid;
        bus.req_rs1     = r1;
        bus.req_rs2     = r2;
        bus.req_rs3     = r3;
        bus.req_use_rs3 = u3;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                done = 1'b1;
                if (push) begin
                    e.wid  = wid;
                    e.d1   = e1;
                    e.d2   = e2;
                    e.d3   = e3;
                    e.rise = cyc + (u3 ? 4 : 3);
                    sb.push_back(e);
                end
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL req_accept_timeout: got no req_ready, want req_ready=1");
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (rdw && done) begin
            bus.wb_valid = 1'b1;
            bus.wb_wid   = wid;
            bus.wb_rd    = rdw_rd;
            bus.wb_tmask = 4'hF;
            bus.wb_data  = rdw_d;
            @(posedge clk); #1;
            bus.wb_valid = 1'b0;
        end
    endtask

    // Wait until every expected bundle has been consumed and the block is idle
    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.req_ready) ok = 1'b1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL rsp_timeout: got %0d bundles outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: latency on valid rise, contents on handshake
    initial begin : monitor
        bit   prev_v = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (bus.rsp_valid && !prev_v && sb.size() != 0)
                    chk_i("rsp_latency_cycle", cyc, sb[0].rise);
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 wid=%0d, want no bundle", bus.rsp_wid);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_wid", DW'(bus.rsp_wid), DW'(e.wid));
                        chk("rs1_data", bus.rsp_rs1_data, e.d1);
                        chk("rs2_data", bus.rsp_rs2_data, e.d2);
                        chk("rs3_data", bus.rsp_rs3_data, e.d3);
                    end
                end
                prev_v = bus.rsp_valid;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout: got simulation still running, want finish");
        $fatal(1, "timeout");
    end

    logic [DW-1:0] v1;
    logic [DW-1:0] pm;

    initial begin : stim
        bit seen;
        v1 = {32'h44, 32'h33, 32'h22, 32'h11};
        pm = {32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAAA, 32'h5555_5555};

        bus.req_valid   = 1'b0;
        bus.req_wid     = '0;
        bus.req_rs1     = '0;
        bus.req_rs2     = '0;
        bus.req_rs3     = '0;
        bus.req_use_rs3 = 1'b0;
        bus.rsp_ready   = 1'b1;
        bus.wb_valid    = 1'b0;
        bus.wb_wid      = '0;
        bus.wb_rd       = '0;
        bus.wb_tmask    = '0;
        bus.wb_data     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", DW'(bus.req_ready), DW'(1));
        chk("reset_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        chk("reset_rsp_wid", DW'(bus.rsp_wid), DW'(0));
        chk("reset_rs1_data", bus.rsp_rs1_data, '0);
        chk("reset_rs2_data", bus.rsp_rs2_data, '0);
        chk("reset_rs3_data", bus.rsp_rs3_data, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full-mask write then read, x0 as rs2, rs3 unused
        wb(2'd1, 5'd5, 4'hF, v1);
        issue(2'd1, 5'd5, 5'd0, 5'd5, 1'b0, v1, '0, '0, 1'b1);
        wait_done();

        // Partial mask write; rs3 used; rs2 reads warp 0 r5 which is still 0
        wb(2'd0, 5'd7, 4'hF, rep(32'hAAAA_AAAA));
        wb(2'd0, 5'd7, 4'b0101, rep(32'h5555_5555));
        issue(2'd0, 5'd7, 5'd5, 5'd7, 1'b1, pm, '0, pm, 1'b1);
        wait_done();

        // rs3 not used: previous nonzero rs3 operand must be cleared
        issue(2'd0, 5'd0, 5'd7, 5'd7, 1'b0, '0, pm, '0, 1'b1);
        wait_done();

        // Writes to x0 are dropped; all-x0 read with rs3
        wb(2'd0, 5'd0, 4'hF, rep(32'hFFFF_FFFF));
        issue(2'd0, 5'd0, 5'd0, 5'd0, 1'b1, '0, '0, '0, 1'b1);
        wait_done();

        // Backpressure with a second request queued behind the stalled bundle
        bus.rsp_ready = 1'b0;
        issue(2'd1, 5'd5, 5'd5, 5'd0, 1'b0, v1, v1, '0, 1'b1);
        fork
            issue(2'd0, 5'd7, 5'd0, 5'd0, 1'b0, pm, '0, '0, 1'b1);
        join_none
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("stall_rsp_seen", DW'(seen), DW'(1));
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_rsp_valid", DW'(bus.rsp_valid), DW'(1));
            chk("stall_req_ready", DW'(bus.req_ready), DW'(0));
            chk("stall_rsp_wid", DW'(bus.rsp_wid), DW'(1));
            chk("stall_rs1_data", bus.rsp_rs1_data, v1);
            chk("stall_rs2_data", bus.rsp_rs2_data, v1);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rsp_req_ready", DW'(bus.req_ready), DW'(1));
        wait_done();
        wait fork;

        // Read-during-write on the rs1 capture edge
        wb(2'd2, 5'd3, 4'hF, rep(32'h1));
        issue(2'd2, 5'd3, 5'd3, 5'd0, 1'b0, rep(32'h1), rep(32'h2), '0, 1'b1,
              1'b1, 5'd3, rep(32'h2));
        wait_done();

        // Reset while in RD2: request discarded, storage cleared
        issue(2'd1, 5'd5, 5'd5, 5'd5, 1'b1, '0, '0, '0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rd2_reset_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        chk("rd2_reset_req_ready", DW'(bus.req_ready), DW'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("discarded_req_no_rsp", DW'(seen), DW'(0));
        chk("post_reset_req_ready", DW'(bus.req_ready), DW'(1));
        issue(2'd1, 5'd5, 5'd5, 5'd5, 1'b1, '0, '0, '0, 1'b1);
        wait_done();
        issue(2'd0, 5'd7, 5'd7, 5'd0, 1'b0, '0, '0, '0, 1'b1);
        wait_done();
        issue(2'd2, 5'd3, 5'd3, 5'd3, 1'b1, '0, '0, '0, 1'b1);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
